pulse_encoder: RTL and testbench
================================

Name: pulse_encoder

Overview:
- Transmit side of the LightIO pulse-interval link; drives the LED/emitter line that the receive-side decoder samples through the limiting amp.
- Accepts one FRAME_SIZE-bit word per valid/ready handshake.
- Serialises the word LSB first as one start pulse followed by one pulse per bit.
- Each bit value is encoded in the number of low cycles before its pulse.

Parameters:
- FRAME_SIZE, default `FRAME_SIZE: bits per frame.
- CNT_W, default `COUNTER_SIZE: width of the interval counter.
- GAP_ZERO, default `INTERVAL_LOW: number of low cycles preceding a 0-bit pulse.
- GAP_ONE, default `INTERVAL_HIGH: number of low cycles preceding a 1-bit pulse.
- GAP_IDLE, default `INTERVAL_HIGH + 2: minimum low cycles after the last pulse before the next start pulse.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- tx_data  in  FRAME_SIZE  word to send; sampled only on acceptance.
- tx_valid  in  1  the word on tx_data is offered.
- tx_ready  out  1  the encoder can accept a word (IDLE state only).
- signal  out  1  emitter drive, registered; 1 = pulse.
- busy  out  1  a frame is in flight (any state except IDLE).
- done  out  1  one-cycle strobe when the guard interval of a frame ends.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; signal = 0; busy = 0; done = 0; tx_ready = 1.
  - Shift register and counters are 0.
  - Reset mid-frame drops signal to 0 immediately; the receiver times out on its own.
- States: IDLE, START, GAP, PULSE, GUARD.
- IDLE:
  - tx_ready = 1.
  - On an edge with tx_valid = 1: latch tx_data into the shift register, set bit index = 0, go to START, signal <= 1.
  - tx_valid while not ready is ignored. tx_data may change freely after acceptance.
- START:
  - signal = 1 for exactly one cycle.
  - Next state GAP, with counter = 0 and signal <= 0.
- GAP:
  - signal = 0. Target = GAP_ONE if the current bit (shift register bit 0) is 1, else GAP_ZERO.
  - Counter increments each cycle.
  - After exactly target low cycles: go to PULSE, signal <= 1.
- PULSE:
  - signal = 1 for exactly one cycle; pulses are never wider than one cycle.
  - Shift the register right and increment the bit index.
  - If the bit index was FRAME_SIZE-1: go to GUARD, counter = 0. Otherwise go back to GAP, counter = 0.
- GUARD:
  - signal = 0 for exactly GAP_IDLE cycles.
  - Then go to IDLE, assert done for one cycle, and set tx_ready = 1 in the same cycle.
  - A word accepted in that IDLE cycle starts the next frame on the following edge. There are no back-to-back frames without the guard.
- Latency and length:
  - First pulse is visible on signal one cycle after the accepting edge.
  - Frame length = 1 + sum over bits of (gap_i + 1) + GAP_IDLE cycles.
- Elaboration checks (generate-time error on failure):
  - GAP_ZERO >= 1.
  - GAP_ZERO < GAP_ONE - 1, so a 0-bit never decodes as a 1-bit.
  - GAP_ONE <= `INTERVAL_HIGH + 1, so the receiver does not time out.
  - GAP_IDLE >= `INTERVAL_HIGH + 2.
  - All gaps fit in CNT_W.
- Width rules:
  - Counter compare is unsigned at CNT_W.
  - Bit index is clog2(FRAME_SIZE)+1 bits wide; wrap-around of the index must never occur.
- busy = 1 from the accepting edge until the cycle done is asserted (exclusive).

Decomposition:
- definitions.v holds FRAME_SIZE, COUNTER_SIZE, INTERVAL_LOW and INTERVAL_HIGH (shared with the decoder).
- Add the state encodings (ENC_IDLE … ENC_GUARD) and ENC_GAP_IDLE to definitions.v.
- No sub-module: a single FSM with a shift register and one down/up counter.
- The bench instantiates the decoder for loopback.

Test Plan (FRAME_SIZE=8, GAP_ZERO=2, GAP_ONE=5, GAP_IDLE=7):
- Reset held low, then released; no tx_valid -> signal = 0, tx_ready = 1, busy = 0 for 20 cycles.
- Send 8'hA5 -> pulse train start, then gaps 5,2,5,2,2,5,2,5; frame is 44 cycles; done strobes once; loopback decoder data = 8'hA5 with irq = 1.
- Send 8'h00, then 8'hFF with tx_valid held high -> second word is accepted in the done cycle; frames are 32 and 56 cycles; decoder yields 00 then FF.
- Toggle tx_data every cycle after acceptance -> transmitted word equals the value latched at acceptance.
- Assert reset at the 3rd bit gap of 8'h3C -> signal = 0 within the same cycle; tx_ready = 1 after release; decoder discards the frame; next frame 8'h81 decodes correctly.
- tx_valid pulsed during GUARD -> ignored; tx_ready stays 0 until the guard expires.

Source files
------------

// File: rtl/pulse_encoder_pkg.sv
// Shared LightIO link definitions: frame and interval defaults, plus the encoder state encodings.
// The receive-side decoder uses the same frame and interval constants.
package pulse_encoder_pkg;

  localparam int DEF_FRAME_SIZE    = 8;
  localparam int DEF_COUNTER_SIZE  = 4;
  localparam int DEF_INTERVAL_LOW  = 2;
  localparam int DEF_INTERVAL_HIGH = 5;

  // The guard must outlast the receiver timeout so that frames stay separable.
  localparam int ENC_GAP_IDLE = DEF_INTERVAL_HIGH + 2;

  typedef enum logic [2:0] {
    ENC_IDLE  = 3'd0,
    ENC_START = 3'd1,
    ENC_GAP   = 3'd2,
    ENC_PULSE = 3'd3,
    ENC_GUARD = 3'd4
  } enc_state_e;

  // Returns the last counter value of an interval of len cycles.
  function automatic int last_count(input int len);
    return len - 1;
  endfunction

endpackage

// File: rtl/pulse_encoder.sv
// Transmit side of the LightIO pulse-interval link. A word is sent LSB first as a start
// pulse followed by one single-cycle pulse per bit; the low gap before each pulse encodes the bit.
//
// state | meaning
// IDLE  | ready for a word, emitter dark
// START | start pulse on the emitter
// GAP   | low cycles encoding the current bit
// PULSE | bit pulse on the emitter
// GUARD | low guard interval so the receiver times out
module pulse_encoder
  import pulse_encoder_pkg::*;
#(
  parameter int FRAME_SIZE = DEF_FRAME_SIZE,
  parameter int CNT_W      = DEF_COUNTER_SIZE,
  parameter int GAP_ZERO   = DEF_INTERVAL_LOW,
  parameter int GAP_ONE    = DEF_INTERVAL_HIGH,
  parameter int GAP_IDLE   = ENC_GAP_IDLE
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [FRAME_SIZE-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  signal,
  output logic                  busy,
  output logic                  done
);

  localparam int BIDX_W = $clog2(FRAME_SIZE) + 1;

  localparam logic [CNT_W-1:0]  ZERO_LAST  = CNT_W'(last_count(GAP_ZERO));
  localparam logic [CNT_W-1:0]  ONE_LAST   = CNT_W'(last_count(GAP_ONE));
  localparam logic [CNT_W-1:0]  GUARD_LAST = CNT_W'(last_count(GAP_IDLE));
  localparam logic [BIDX_W-1:0] BIDX_LAST  = BIDX_W'(FRAME_SIZE - 1);

  generate
    if (FRAME_SIZE < 1) begin : g_chk_frame
      $error("pulse_encoder: FRAME_SIZE must be at least 1");
    end
    if (GAP_ZERO < 1) begin : g_chk_zero
      $error("pulse_encoder: GAP_ZERO must be at least 1");
    end
    if (GAP_ZERO >= GAP_ONE - 1) begin : g_chk_sep
      $error("pulse_encoder: GAP_ZERO must be below GAP_ONE - 1");
    end
    if (GAP_ONE > DEF_INTERVAL_HIGH + 1) begin : g_chk_one
      $error("pulse_encoder: GAP_ONE exceeds the receiver timeout");
    end
    if (GAP_IDLE < DEF_INTERVAL_HIGH + 2) begin : g_chk_idle
      $error("pulse_encoder: GAP_IDLE shorter than the receiver timeout");
    end
    if ((GAP_ONE - 1) >= (1 << CNT_W) || (GAP_IDLE - 1) >= (1 << CNT_W)) begin : g_chk_cnt
      $error("pulse_encoder: gaps do not fit in CNT_W");
    end
  endgenerate

  enc_state_e              state, state_next;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic [FRAME_SIZE-1:0]   shreg, shreg_next;
  logic [BIDX_W-1:0]       bidx, bidx_next;
  logic                    signal_next;
  logic                    done_next;
  logic [CNT_W-1:0]        gap_last;

  assign gap_last = shreg[0] ? ONE_LAST : ZERO_LAST;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= ENC_IDLE;
      cnt    <= '0;
      shreg  <= '0;
      bidx   <= '0;
      signal <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      shreg  <= shreg_next;
      bidx   <= bidx_next;
      signal <= signal_next;
      done   <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    shreg_next = shreg;
    bidx_next  = bidx;
    done_next  = 1'b0;
    unique case (state)
      ENC_IDLE: begin
        if (tx_valid) begin
          shreg_next = tx_data;
          bidx_next  = '0;
          state_next = ENC_START;
        end
      end
      ENC_START: begin
        cnt_next   = '0;
        state_next = ENC_GAP;
      end
      ENC_GAP: begin
        if (cnt == gap_last) begin
          cnt_next   = '0;
          state_next = ENC_PULSE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ENC_PULSE: begin
        shreg_next = shreg >> 1;
        bidx_next  = bidx + 1'b1;
        cnt_next   = '0;
        state_next = (bidx == BIDX_LAST) ? ENC_GUARD : ENC_GAP;
      end
      ENC_GUARD: begin
        if (cnt == GUARD_LAST) begin
          cnt_next   = '0;
          done_next  = 1'b1;
          state_next = ENC_IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = ENC_IDLE;
      end
    endcase
  end

  // Emitter is registered from the next state, so each pulse is exactly one cycle wide.
  assign signal_next = (state_next == ENC_START) || (state_next == ENC_PULSE);

  assign tx_ready = (state == ENC_IDLE);
  assign busy     = (state != ENC_IDLE);

endmodule

// File: tb/tb_pulse_encoder.sv
// Directed bench for pulse_encoder with a behavioural loopback decoder on the emitter line.
module tb_pulse_encoder;

  localparam int FS = 8;
  localparam int CW = 4;
  localparam int G0 = 2;
  localparam int G1 = 5;
  localparam int GI = 7;
  localparam int BIT_THRESH = 4;

  typedef struct {
    logic [7:0] data;
    int         len;
    bit         toggle;
    bit         poke;
  } vec_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [FS-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready, signal, busy, done;

  int vectors = 0;
  int miscompares = 0;

  pulse_encoder #(
    .FRAME_SIZE(FS), .CNT_W(CW), .GAP_ZERO(G0), .GAP_ONE(G1), .GAP_IDLE(GI)
  ) dut (
    .clock(clock), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .signal(signal), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Loopback receiver: pulse starts a frame, gap length decides bit, long low times out.
  logic [7:0] dec_sr = '0;
  logic [7:0] dec_q[$];
  int         dec_gaps[$];
  int         dec_low = 0;
  int         dec_bits = 0;
  int         dec_irq = 0;
  bit         dec_active = 0;
  bit         prev_sig = 0;

  always @(negedge clock) begin
    if (signal) begin
      check("pulse_width", int'(prev_sig), 0);
      if (!dec_active) begin
        dec_active = 1;
        dec_bits = 0;
        dec_gaps.delete();
      end else begin
        dec_sr = {(dec_low >= BIT_THRESH), dec_sr[7:1]};
        dec_gaps.push_back(dec_low);
        dec_bits++;
      end
      dec_low = 0;
    end else if (dec_active) begin
      dec_low++;
      if (dec_low > G1 + 1) begin
        dec_active = 0;
        if (dec_bits == FS) begin
          dec_q.push_back(dec_sr);
          dec_irq++;
        end
      end
    end
    prev_sig = signal;
  end

  task automatic check_decoded(input string name, input logic [7:0] exp);
    check({name, "_cnt"}, dec_q.size(), 1);
    if (dec_q.size() > 0) check({name, "_word"}, dec_q.pop_front(), exp);
    dec_q.delete();
  endtask

  // Counts busy cycles until done; returns the length and whether done arrived.
  task automatic count_frame(input bit toggle, input bit poke, input int exp_len,
                             output int len, output bit seen, output logic busy_at_done);
    len = 0;
    seen = 0;
    busy_at_done = 1'b1;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clock);
      if (done) begin
        seen = 1;
        busy_at_done = busy;
      end else begin
        if (busy) len++;
        if (toggle) tx_data = ~tx_data ^ 8'(c);
        if (poke && len == exp_len - 3) begin
          tx_data = 8'hEE;
          tx_valid = 1'b1;
          check("guard_ready", tx_ready, 0);
        end else if (poke && len == exp_len - 2) begin
          check("guard_ready2", tx_ready, 0);
          tx_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic run_frame(input logic [7:0] d, input int exp_len, input bit toggle, input bit poke);
    int   len;
    bit   seen;
    logic bd;
    dec_q.delete();
    @(negedge clock);
    check("ready_idle", tx_ready, 1);
    tx_data = d;
    tx_valid = 1'b1;
    @(posedge clock);
    #1;
    tx_valid = 1'b0;
    count_frame(toggle, poke, exp_len, len, seen, bd);
    check("done_seen", int'(seen), 1);
    check("frame_len", len, exp_len);
    check("busy_at_done", bd, 0);
    @(negedge clock);
    check("done_width", done, 0);
    if (poke) begin
      for (int k = 0; k < 3; k++) begin
        check("poke_ignored", busy, 0);
        @(negedge clock);
      end
    end
    check_decoded("decode", d);
  endtask

  vec_t tbl [6];
  int   exp_gaps [8] = '{5, 2, 5, 2, 2, 5, 2, 5};

  initial begin
    int   len;
    bit   seen;
    logic bd;
    int   pulses;

    tbl[0] = '{8'hA5, 44, 1'b0, 1'b0};
    tbl[1] = '{8'h3C, 44, 1'b0, 1'b0};
    tbl[2] = '{8'h01, 35, 1'b0, 1'b1};
    tbl[3] = '{8'h80, 35, 1'b0, 1'b0};
    tbl[4] = '{8'h96, 44, 1'b1, 1'b0};
    tbl[5] = '{8'h7E, 50, 1'b0, 1'b0};

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_outputs", {signal, tx_ready, busy, done}, 4'b0100);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("idle_outputs", {signal, tx_ready, busy, done}, 4'b0100);
    end

    for (int i = 0; i < 6; i++) begin
      run_frame(tbl[i].data, tbl[i].len, tbl[i].toggle, tbl[i].poke);
      if (i == 0) begin
        check("a5_gap_cnt", dec_gaps.size(), 8);
        for (int g = 0; g < 8 && g < dec_gaps.size(); g++) check("a5_gap", dec_gaps[g], exp_gaps[g]);
      end
    end

    // Back-to-back: second word accepted in the done cycle.
    dec_q.delete();
    @(negedge clock);
    tx_data = 8'h00;
    tx_valid = 1'b1;
    @(posedge clock);
    #1;
    tx_data = 8'hFF;
    count_frame(1'b0, 1'b0, 32, len, seen, bd);
    check("b2b_done0", int'(seen), 1);
    check("b2b_len0", len, 32);
    check("b2b_ready_done", tx_ready, 1);
    @(posedge clock);
    #1;
    tx_valid = 1'b0;
    count_frame(1'b0, 1'b0, 56, len, seen, bd);
    check("b2b_done1", int'(seen), 1);
    check("b2b_len1", len, 56);
    check("b2b_cnt", dec_q.size(), 2);
    if (dec_q.size() == 2) begin
      check("b2b_word0", dec_q[0], 8'h00);
      check("b2b_word1", dec_q[1], 8'hFF);
    end
    dec_q.delete();

    // Reset in the third bit gap of 8'h3C.
    @(negedge clock);
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    @(posedge clock);
    #1;
    tx_valid = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40 && pulses < 3; c++) begin
      @(negedge clock);
      if (signal) pulses++;
    end
    check("rst_pulses_seen", pulses, 3);
    @(negedge clock);
    check("rst_in_gap_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_outputs", {signal, tx_ready, busy, done}, 4'b0100);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (10) @(negedge clock);
    check("rst_ready_after", tx_ready, 1);
    check("rst_discard", dec_q.size(), 0);
    run_frame(8'h81, 38, 1'b0, 1'b0);

    // Reset while the start pulse is on the line: emitter must drop without a clock edge.
    @(negedge clock);
    tx_data = 8'h01;
    tx_valid = 1'b1;
    @(posedge clock);
    #1;
    tx_valid = 1'b0;
    @(negedge clock);
    check("start_pulse_high", signal, 1);
    #1 reset = 1'b0;
    #1;
    check("async_drop", signal, 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (10) @(negedge clock);
    check("start_rst_discard", dec_q.size(), 0);

    check("irq_count", dec_irq, 9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
